// File: rtl/ov7670_capture_pkg.sv
// Shared capture/display definitions: frame geometry defaults, bus widths and
// the camera byte-pairing FSM encoding.
package ov7670_capture_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int ADDR_W       = 19;
  localparam int PIX_W        = 12;
  localparam int PCNT_W       = 10;
  localparam int LCNT_W       = 9;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PIX_W-1:0]  pixel_t;

  typedef enum logic [1:0] {
    SYNC_WAIT_ACT,
    SYNC_WAIT_INACT,
    BYTE0,
    BYTE1
  } cap_state_e;

endpackage

// File: rtl/ov7670_capture_if.sv
// Camera input bus plus frame-buffer write port of the OV7670 capture block.
interface ov7670_capture_if;
  import ov7670_capture_pkg::*;

  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_data;
  addr_t      frame_addr;
  pixel_t     frame_pixel;
  logic       frame_we;
  logic       frame_done;

  modport master (
    output cam_vsync, cam_href, cam_data,
    input  frame_addr, frame_pixel, frame_we, frame_done
  );

  modport slave (
    input  cam_vsync, cam_href, cam_data,
    output frame_addr, frame_pixel, frame_we, frame_done
  );

endinterface

// File: rtl/ov7670_byte_pair.sv
// Frame-sync FSM and RGB444 byte pairing: byte0 carries red, byte1 green/blue.
module ov7670_byte_pair
  import ov7670_capture_pkg::*;
(
  input  logic       clk25,
  input  logic       rst,
  input  logic       vs_act,
  input  logic       href,
  input  logic [7:0] data,
  output logic       pix_req,
  output pixel_t     pix_data
);

  cap_state_e state_q, state_d;
  logic [3:0] red_q, red_d;

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q <= SYNC_WAIT_ACT;
      red_q   <= '0;
    end else begin
      state_q <= state_d;
      red_q   <= red_d;
    end
  end

  // Active vsync masks href in the byte states; a low href always re-aligns to BYTE0.
  always_comb begin
    state_d  = state_q;
    red_d    = red_q;
    pix_req  = 1'b0;
    pix_data = {red_q, data};
    unique case (state_q)
      SYNC_WAIT_ACT:   if (vs_act) state_d = SYNC_WAIT_INACT;
      SYNC_WAIT_INACT: if (!vs_act) state_d = BYTE0;
      BYTE0: begin
        if (!vs_act && href) begin
          red_d   = data[3:0];
          state_d = BYTE1;
        end
      end
      BYTE1: begin
        state_d = BYTE0;
        if (!vs_act && href) pix_req = 1'b1;
      end
      default: state_d = SYNC_WAIT_ACT;
    endcase
  end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture: registers the camera bus, pairs bytes into pixels and
// writes them row-major into a frame buffer with clipping and saturation.
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int   H_ACTIVE     = H_ACTIVE_DEF,
  parameter int   V_ACTIVE     = V_ACTIVE_DEF,
  parameter logic VSYNC_ACTIVE = 1'b1
) (
  input  logic             clk25,
  input  logic             rst,
  ov7670_capture_if.slave  bus
);

  localparam addr_t ADDR_MAX = addr_t'(H_ACTIVE * V_ACTIVE - 1);

  logic              vs_q, vs_prev_q, href_q, href_prev_q;
  logic [7:0]        data_q;
  addr_t             frame_addr_q, frame_addr_d;
  pixel_t            frame_pixel_q, frame_pixel_d;
  logic              frame_we_q, frame_we_d;
  logic              frame_done_q, frame_done_d;
  logic              wrote_q, wrote_d;
  logic [PCNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [LCNT_W-1:0] line_cnt_q, line_cnt_d;

  logic   vs_act, vs_edge, href_fall, in_window, do_wr, pix_req;
  pixel_t pix_data;

  ov7670_byte_pair u_byte_pair (
    .clk25    (clk25),
    .rst      (rst),
    .vs_act   (vs_act),
    .href     (href_q),
    .data     (data_q),
    .pix_req  (pix_req),
    .pix_data (pix_data)
  );

  always_ff @(posedge clk25) begin
    if (rst) begin
      vs_q          <= 1'b0;
      vs_prev_q     <= 1'b0;
      href_q        <= 1'b0;
      href_prev_q   <= 1'b0;
      data_q        <= '0;
      frame_addr_q  <= '0;
      frame_pixel_q <= '0;
      frame_we_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      wrote_q       <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
    end else begin
      vs_q          <= bus.cam_vsync;
      vs_prev_q     <= vs_q;
      href_q        <= bus.cam_href;
      href_prev_q   <= href_q;
      data_q        <= bus.cam_data;
      frame_addr_q  <= frame_addr_d;
      frame_pixel_q <= frame_pixel_d;
      frame_we_q    <= frame_we_d;
      frame_done_q  <= frame_done_d;
      wrote_q       <= wrote_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
    end
  end

  // pix_req is already masked while vsync is active, so a write coincident with
  // the frame-start edge is dropped and the clear below wins.
  always_comb begin
    vs_act    = (vs_q == VSYNC_ACTIVE);
    vs_edge   = vs_act && (vs_prev_q != VSYNC_ACTIVE);
    href_fall = href_prev_q && !href_q && !vs_act;
    in_window = (int'(pix_cnt_q) < H_ACTIVE) && (int'(line_cnt_q) < V_ACTIVE);
    do_wr     = pix_req && in_window;

    frame_we_d    = do_wr;
    frame_pixel_d = do_wr ? pix_data : frame_pixel_q;
    frame_done_d  = vs_edge && wrote_q;

    frame_addr_d = frame_addr_q;
    if (vs_edge)
      frame_addr_d = '0;
    else if (frame_we_q && frame_addr_q != ADDR_MAX)
      frame_addr_d = frame_addr_q + addr_t'(1);

    wrote_d = wrote_q;
    if (vs_edge)    wrote_d = 1'b0;
    else if (do_wr) wrote_d = 1'b1;

    pix_cnt_d = pix_cnt_q;
    if (vs_edge || href_fall)
      pix_cnt_d = '0;
    else if (pix_req && pix_cnt_q != '1)
      pix_cnt_d = pix_cnt_q + PCNT_W'(1);

    line_cnt_d = line_cnt_q;
    if (vs_edge)
      line_cnt_d = '0;
    else if (href_fall && line_cnt_q != '1)
      line_cnt_d = line_cnt_q + LCNT_W'(1);
  end

  assign bus.frame_addr  = frame_addr_q;
  assign bus.frame_pixel = frame_pixel_q;
  assign bus.frame_we    = frame_we_q;
  assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomised frame/line stimulus for ov7670_capture, checked every cycle against
// expectations planned from the frame geometry before the run starts.
module tb_ov7670_capture;

  localparam int H    = 24;
  localparam int V    = 10;
  localparam int AMAX = H * V - 1;
  localparam int MAXC = 20000;

  logic clk25 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk25 = ~clk25;

  ov7670_capture_if bus ();

  ov7670_capture #(
    .H_ACTIVE     (H),
    .V_ACTIVE     (V),
    .VSYNC_ACTIVE (1'b1)
  ) dut (
    .clk25 (clk25),
    .rst   (rst),
    .bus   (bus)
  );

  // Planned stimulus and expected outputs, indexed by rising-edge number.
  bit          st_vs   [MAXC];
  bit          st_href [MAXC];
  bit          st_rst  [MAXC];
  logic [7:0]  st_data [MAXC];
  bit          exp_we  [MAXC];
  bit          exp_done[MAXC];
  bit          exp_clr [MAXC];
  logic [11:0] exp_pix [MAXC];
  int          exp_addr[MAXC];

  int n = 0;
  bit synced = 1'b0;
  bit wrote  = 1'b0;
  int line_idx = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic push(input bit vs, input bit href, input logic [7:0] d, input bit r);
    if (n >= MAXC - 2) begin
      $display("FAIL plan_overflow: got %0d cycles, limit %0d", n, MAXC - 2);
      $fatal(1);
    end
    st_vs[n] = vs; st_href[n] = href; st_data[n] = d; st_rst[n] = r;
    n++;
  endtask

  // Frame start seen at cycle c: clear lands one edge later, done only if the frame wrote.
  task automatic edge_event(input int c);
    exp_clr[c+1] = 1'b1;
    if (wrote) exp_done[c+1] = 1'b1;
    wrote    = 1'b0;
    line_idx = 0;
  endtask

  task automatic idle(input int k);
    repeat (k) push(1'b0, 1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic do_reset(input int k);
    repeat (k) push(1'b0, 1'b0, 8'($urandom), 1'b1);
    synced = 1'b0; wrote = 1'b0; line_idx = 0;
  endtask

  task automatic vsync_pulse(input int k, input bit noise, input bit cont);
    for (int i = 0; i < k; i++) begin
      if (i == 0 && !cont) edge_event(n);
      push(1'b1, (noise && i > 0 && i < k - 1) ? 1'($urandom) : 1'b0, 8'($urandom), 1'b0);
    end
    synced = 1'b1;
  endtask

  task automatic line(input int nbytes, input bit vs_cut, input bit fixed);
    logic [7:0] d, b0;
    bit last;
    b0 = '0;
    for (int b = 0; b < nbytes; b++) begin
      d    = fixed ? ((b % 2 == 0) ? 8'h0A : 8'hBC) : 8'($urandom);
      last = (b == nbytes - 1);
      if (b % 2 == 0) b0 = d;
      else if (vs_cut && last) edge_event(n);
      else if (synced && b / 2 < H && line_idx < V) begin
        exp_we[n+1]  = 1'b1;
        exp_pix[n+1] = {b0[3:0], d};
        wrote = 1'b1;
      end
      push(vs_cut && last, 1'b1, d, 1'b0);
    end
    if (!vs_cut) begin
      if (line_idx < 511) line_idx++;
      idle($urandom_range(1, 3));
    end
  endtask

  function automatic int count_we(input int a, input int b);
    int k = 0;
    for (int i = a; i <= b; i++) if (exp_we[i]) k++;
    return k;
  endfunction

  int s1, p1, f0, f1, g0, g1, o0, o1, t0, t1, r0;
  int cur;

  initial begin
    bus.cam_vsync = 1'b0;
    bus.cam_href  = 1'b0;
    bus.cam_data  = '0;

    // Reset, sync, one full line of 0x0A/0xBC pairs.
    do_reset(3); idle(3);
    vsync_pulse(4, 1'b0, 1'b0); idle(3);
    s1 = n; line(2 * H, 1'b0, 1'b1);
    p1 = n; vsync_pulse(5, 1'b1, 1'b0); idle(3);

    // Full frame, then a frame with a 3-byte line among full lines.
    f0 = n;
    for (int l = 0; l < V; l++) line(2 * H, 1'b0, 1'b0);
    f1 = n; vsync_pulse(4, 1'b0, 1'b0); idle(3);
    line(2 * H, 1'b0, 1'b0);
    g0 = n; line(3, 1'b0, 1'b0); g1 = n;
    line(2 * H, 1'b0, 1'b0);
    vsync_pulse(3, 1'b1, 1'b0); idle(2);

    // Oversized frame: long lines and extra lines are clipped, address saturates.
    o0 = n;
    for (int l = 0; l < V + 3; l++) line(2 * (H + 6), 1'b0, 1'b0);
    o1 = n; vsync_pulse(4, 1'b0, 1'b0); idle(3);

    // Vsync asserts on the byte that would complete a pixel.
    line(2 * H, 1'b0, 1'b0); line(2 * 5, 1'b0, 1'b0);
    t0 = n; line(2 * 5, 1'b1, 1'b0); t1 = n;
    vsync_pulse(4, 1'b0, 1'b1); idle(3);

    // Reset mid-frame: nothing written until a full vsync pulse is seen again.
    for (int l = 0; l < 4; l++) line(2 * H, 1'b0, 1'b0);
    idle(3); r0 = n; do_reset(2); idle(2);
    for (int l = 0; l < 3; l++) line(2 * H, 1'b0, 1'b0);
    vsync_pulse(4, 1'b1, 1'b0); idle(3);
    line(2 * H, 1'b0, 1'b0); line(9, 1'b0, 1'b0);

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      vsync_pulse($urandom_range(2, 6), 1'b1, 1'b0);
      idle($urandom_range(2, 4));
      for (int l = 0; l < int'($urandom_range(1, V + 2)); l++)
        line($urandom_range(1, 2 * H + 8), 1'b0, 1'b0);
    end
    vsync_pulse(4, 1'b0, 1'b0); idle(5);

    // Address trace: holds between writes, steps after each, saturates, clears on frame start.
    cur = 0;
    for (int c = 0; c < n; c++) begin
      if (st_rst[c]) begin
        exp_we[c] = 1'b0; exp_done[c] = 1'b0; cur = 0;
      end else if (exp_clr[c]) cur = 0;
      exp_addr[c] = cur;
      if (exp_we[c]) cur = (cur < AMAX) ? cur + 1 : AMAX;
    end

    // Hand-derived pins on the plan.
    chk("pin_line_writes", s1, 32'(count_we(s1, p1)), 32'd24);
    chk("pin_first_we", s1 + 2, 32'(exp_we[s1+2]), 32'd1);
    chk("pin_first_pix", s1 + 2, 32'(exp_pix[s1+2]), 32'hABC);
    chk("pin_line_last_addr", p1, 32'(exp_addr[p1]), 32'd24);
    chk("pin_done", p1 + 1, 32'(exp_done[p1+1]), 32'd1);
    chk("pin_frame_writes", f0, 32'(count_we(f0, f1)), 32'd240);
    chk("pin_frame_sat", f1, 32'(exp_addr[f1]), 32'd239);
    chk("pin_odd_line", g0, 32'(count_we(g0 + 1, g1)), 32'd1);
    chk("pin_clip_writes", o0, 32'(count_we(o0, o1)), 32'd240);
    chk("pin_cut_addr", t1, 32'(exp_addr[t1]), 32'd0);
    chk("pin_cut_writes", t0, 32'(count_we(t0, t1 + 1)), 32'd4);
    chk("pin_reset_addr", r0 + 3, 32'(exp_addr[r0+3]), 32'd0);

    // Drive on the falling edge, compare just after each rising edge.
    for (int c = 0; c < n; c++) begin
      @(negedge clk25);
      rst           = st_rst[c];
      bus.cam_vsync = st_vs[c];
      bus.cam_href  = st_href[c];
      bus.cam_data  = st_data[c];
      @(posedge clk25);
      #1;
      chk("frame_we", c, 32'(bus.frame_we), 32'(exp_we[c]));
      chk("frame_done", c, 32'(bus.frame_done), 32'(exp_done[c]));
      chk("frame_addr", c, 32'(bus.frame_addr), 32'(exp_addr[c]));
      if (exp_we[c]) chk("frame_pixel", c, 32'(bus.frame_pixel), 32'(exp_pix[c]));
      if (st_rst[c]) chk("reset_pixel", c, 32'(bus.frame_pixel), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640, SHALL set the pixels stored per line.
REQ-002 Parameter V_ACTIVE, default 480, SHALL set the lines stored per frame.
REQ-003 Parameter VSYNC_ACTIVE, default 1'b1, SHALL set the camera vsync active level.
REQ-004 clk25  input  1  SHALL be the camera pixel clock; all logic is on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 cam_vsync  input  1  SHALL be the camera frame sync.
REQ-007 cam_href  input  1  SHALL be the camera line-valid signal, high while bytes are valid.
REQ-008 cam_data  input  8  SHALL be the camera byte bus in RGB444 mode: byte0 = xxxxRRRR, byte1 = GGGGBBBB.
REQ-009 frame_addr  output  19  SHALL be the frame-buffer write address, row-major from 0.
REQ-010 frame_pixel  output  12  SHALL be the write data {R,G,B}, 4 bits per colour, matching the display-side read format.
REQ-011 frame_we  output  1  SHALL be the frame-buffer write enable, one cycle per stored pixel.
REQ-012 frame_done  output  1  SHALL be a one-cycle pulse marking the end of a captured frame.

Function
REQ-013 cam_vsync, cam_href and cam_data SHALL be registered once before use; all timing below refers to these registered copies.
REQ-014 The FSM SHALL have states SYNC_WAIT_ACT, SYNC_WAIT_INACT, BYTE0 and BYTE1.
REQ-015 SYNC_WAIT_ACT SHALL go to SYNC_WAIT_INACT when registered vsync equals VSYNC_ACTIVE.
REQ-016 SYNC_WAIT_INACT SHALL go to BYTE0 when vsync becomes inactive; no writes occur in either SYNC state.
REQ-017 In BYTE0 with href high, the FSM SHALL latch cam_data[3:0] as red and go to BYTE1.
REQ-018 In BYTE1 with href high, the FSM SHALL form the pixel {red, byte[7:4], byte[3:0]}, go to BYTE0, and request a write.
REQ-019 A write request SHALL drive frame_we=1 for one cycle on the edge after the BYTE1 byte is registered (2 cycles after it is on cam_data), with frame_pixel and frame_addr valid that same cycle.
REQ-020 After each performed write, frame_addr SHALL increment by 1.
REQ-021 A 10-bit pixel counter SHALL count pixels in the current line.
REQ-022 A 9-bit line counter SHALL count lines in the current frame.
REQ-023 A write request SHALL be suppressed when pixel count >= H_ACTIVE or line count >= V_ACTIVE.
REQ-024 frame_addr SHALL saturate at H_ACTIVE*V_ACTIVE-1 (307199) and never wrap within a frame.
REQ-025 On an href falling edge, the FSM SHALL return to BYTE0 and discard any unpaired BYTE0 byte.
REQ-026 On an href falling edge, the pixel counter SHALL clear and the line counter SHALL increment, saturating at 511.
REQ-027 On a vsync active edge, frame_addr, the pixel counter and the line counter SHALL clear and the FSM SHALL return to BYTE0.
REQ-028 A vsync active edge SHALL pulse frame_done for one cycle if at least one write occurred since the previous frame start.
REQ-029 href activity while vsync is active SHALL be ignored.
REQ-030 If the vsync edge and a write request fall in the same cycle, the write SHALL be dropped and the clear SHALL take priority.
REQ-031 A short line (< H_ACTIVE pixels) SHALL NOT pad; the next line continues from the current frame_addr.

Reset
REQ-032 On rst, the FSM SHALL enter SYNC_WAIT_ACT.
REQ-033 On rst, frame_addr, frame_pixel, the counters and the input registers SHALL be 0.
REQ-034 On rst, frame_we and frame_done SHALL be 0.
REQ-035 A reset mid-frame SHALL suppress all writes until a full vsync active-then-inactive sequence has been observed.

Structure
REQ-036 A shared package SHALL hold H_ACTIVE/V_ACTIVE defaults, the 19-bit address width, the 12-bit pixel width and the FSM state encoding, shared with the display-side timing block.
REQ-037 A sub-module ov7670_byte_pair (FSM plus byte packing) is natural; counters and address logic stay in the top.

Verification
REQ-038 Reset, vsync pulse, then 1 line of 640 byte pairs 0x0A,0xBC -> 640 writes, frame_pixel=0xABC, frame_addr 0..639, frame_we first high 2 cycles after the first 0xBC.
REQ-039 Full 640x480 frame, then vsync -> 307200 writes, last address 307199, one frame_done pulse, next frame restarts at address 0.
REQ-040 Line with 700 pixels and frame with 500 lines -> writes only for pixels 0..639 and lines 0..479; address never exceeds 307199.
REQ-041 href drops after an odd byte (3 bytes) -> exactly 1 write; the next line's first pixel pairs correctly.
REQ-042 Reset asserted at line 100 -> no writes until vsync active then inactive; the following frame starts at address 0.
REQ-043 Vsync active edge coincident with a pending write -> no write that cycle; frame_addr=0 next cycle.
